td4_exec_unit: RTL
==================

# td4_exec_unit

Execution stage of the TD4 4-bit CPU, directly upstream of the carry-flag flip-flop. It decodes the 8-bit instruction from program ROM, owns the A, B, OUT and PC registers, and computes the 4-bit ALU sum. It drives `carry_out` into the flag flip-flop's D input and consumes that flip-flop's Q output as `carry_q` for conditional jumps.

## Interface
- No parameters. Data width is fixed at 4 bits and instruction width at 8 bits.
- `clk` input 1: system clock. All state updates on the rising edge.
- `clr_n` input 1: asynchronous, active-low reset.
- `instr` input 8: current instruction. `instr[7:4]` is the opcode and `instr[3:0]` is Im.
- `carry_q` input 1: registered carry flag from the downstream flag flip-flop.
- `in_port` input 4: external input switches.
- `carry_out` output 1: combinational adder carry, wired to the flag flip-flop's D input.
- `pc` output 4: program counter, used as the ROM address.
- `out_port` output 4: OUT register.
- `reg_a` output 4: A register (observation).
- `reg_b` output 4: B register (observation).
- `halted` output 1: present only with `TD4_EXEC_HALT_EN`.

## Operation
- Adder: `sum[4:0] = src + addend`, zero-extended. The result written to any register is `sum[3:0]`. `carry_out = sum[4]`.
- Opcode table (entries give src, addend, then the action):
  - 0000 ADD A,Im: A, Im, A←sum.
  - 0101 ADD B,Im: B, Im, B←sum.
  - 0011 MOV A,Im: 0, Im, A←sum.
  - 0111 MOV B,Im: 0, Im, B←sum.
  - 0001 MOV A,B: B, 0, A←sum.
  - 0100 MOV B,A: A, 0, B←sum.
  - 0010 IN A: in_port, 0, A←sum.
  - 0110 IN B: in_port, 0, B←sum.
  - 1001 OUT B: B, 0, OUT←sum.
  - 1011 OUT Im: 0, Im, OUT←sum.
  - 1111 JMP Im: 0, Im, PC←sum.
  - 1110 JNC Im: 0, Im, PC←sum when `carry_q`=0, otherwise PC←PC+1.
- Undefined opcodes (1000, 1010, 1100, 1101): src=0 and addend=0, no register loaded, PC←PC+1.
- Only the ADD instructions can produce `carry_out`=1. Every other opcode yields `carry_out`=0, so the flag clears on any non-ADD instruction.
- PC increments modulo 16 on every non-jump cycle and on a not-taken JNC. 15 wraps to 0.
- At most one of A, B, OUT, PC is loaded from `sum` per cycle. Registers not loaded hold their value, except PC, which increments.

## Timing
- Reset (`clr_n`=0): A, B, OUT, PC clear to 0 immediately (asynchronous), and `halted`=0.
  - Reset mid-instruction aborts the update.
  - The first instruction executed after release is at address 0.
- One instruction per clock, single-cycle. Register writes occur at the rising edge ending the cycle in which `instr` is presented.
- `carry_out` is valid combinationally within the same cycle. The flag flip-flop captures it on the same edge, so `carry_q` reflects the previous instruction's carry.
- JNC tests `carry_q` as sampled at the edge: the carry of the immediately preceding instruction.
- `reg_a`, `reg_b`, `out_port` and `pc` are direct register outputs with no combinational path from `instr`.

## Configuration
- `TD4_EXEC_HALT_EN` defined:
  - Adds output `halted`.
  - `halted` sets on the edge that executes JMP with Im equal to the current PC.
  - While `halted`=1, A, B, OUT and PC freeze, and `carry_out` is forced to 0.
  - Only `clr_n` clears `halted`.
- `TD4_EXEC_HALT_EN` undefined: no `halted` port. A self-JMP simply reloads PC every cycle.

## Test plan
- Reset: hold `clr_n`=0 for 3 clocks with random `instr` → pc=0, reg_a=0, reg_b=0, out_port=0. Asserting `clr_n` mid-cycle clears everything immediately.
- ADD overflow:
  - Stimulus: MOV A,0xE, then ADD A,1, then ADD A,1.
  - reg_a sequence is E, F, 0.
  - `carry_out` is 0, then 1 on the second ADD.
  - pc advances 0, 1, 2, 3.
- JNC:
  - JNC 5 following the overflowing ADD (`carry_q`=1) → pc=PC+1.
  - JNC 5 following MOV B,0 (`carry_q`=0) → pc=5.
- I/O:
  - in_port=0xA, IN B, then OUT B → reg_b=A, then out_port=A.
  - OUT 0x3 → out_port=3.
  - MOV A,B copies B without altering B.
- PC wrap and undefined opcodes: run opcode 1000 for 17 cycles from reset → pc steps 0…15, 0, 1. Registers unchanged, `carry_out`=0.
- Halt (with `TD4_EXEC_HALT_EN`):
  - JMP 4 executed at pc=4 → `halted`=1 next edge. Later instructions change nothing.
  - `clr_n` pulse → `halted`=0, pc=0.

Source files
------------

// File: rtl/td4_exec_unit.sv
// TD4 execution stage: instruction decode, 4-bit adder, and the A/B/OUT/PC registers.
// Optional halt-on-self-jump support is enabled by defining TD4_EXEC_HALT_EN.
module td4_exec_unit (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [7:0] instr,
  input  logic       carry_q,
  input  logic [3:0] in_port,
  output logic       carry_out,
  output logic [3:0] pc,
  output logic [3:0] out_port,
  output logic [3:0] reg_a,
  output logic [3:0] reg_b
`ifdef TD4_EXEC_HALT_EN
  ,
  output logic       halted
`endif
);

  logic [3:0] opcode;
  logic [3:0] imm;
  logic [3:0] src;
  logic [3:0] addend;
  logic [4:0] sum;
  logic       ld_a;
  logic       ld_b;
  logic       ld_out;
  logic       ld_pc;
  logic       frozen;

  assign opcode = instr[7:4];
  assign imm    = instr[3:0];

  // Each opcode selects the adder operands and at most one destination register.
  always_comb begin
    src    = 4'h0;
    addend = 4'h0;
    ld_a   = 1'b0;
    ld_b   = 1'b0;
    ld_out = 1'b0;
    ld_pc  = 1'b0;
    case (opcode)
      4'b0000: begin src = reg_a;   addend = imm; ld_a = 1'b1; end
      4'b0101: begin src = reg_b;   addend = imm; ld_b = 1'b1; end
      4'b0011: begin                addend = imm; ld_a = 1'b1; end
      4'b0111: begin                addend = imm; ld_b = 1'b1; end
      4'b0001: begin src = reg_b;                 ld_a = 1'b1; end
      4'b0100: begin src = reg_a;                 ld_b = 1'b1; end
      4'b0010: begin src = in_port;               ld_a = 1'b1; end
      4'b0110: begin src = in_port;               ld_b = 1'b1; end
      4'b1001: begin src = reg_b;                 ld_out = 1'b1; end
      4'b1011: begin                addend = imm; ld_out = 1'b1; end
      4'b1111: begin                addend = imm; ld_pc = 1'b1; end
      4'b1110: begin                addend = imm; ld_pc = ~carry_q; end
      default: begin end
    endcase
  end

  assign sum       = {1'b0, src} + {1'b0, addend};
  assign carry_out = sum[4] & ~frozen;

`ifdef TD4_EXEC_HALT_EN
  // A JMP to its own address parks the core until the next reset.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)
      halted <= 1'b0;
    else if (!halted && opcode == 4'b1111 && imm == pc)
      halted <= 1'b1;
  end

  assign frozen = halted;
`else
  assign frozen = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      reg_a    <= 4'h0;
      reg_b    <= 4'h0;
      out_port <= 4'h0;
      pc       <= 4'h0;
    end else if (!frozen) begin
      if (ld_a)   reg_a    <= sum[3:0];
      if (ld_b)   reg_b    <= sum[3:0];
      if (ld_out) out_port <= sum[3:0];
      pc <= ld_pc ? sum[3:0] : pc + 4'h1;
    end
  end

endmodule
